// File: rtl/alt_pkg.sv
// Shared types and helpers for the ambient-light frame scheduler.
// Job and state encodings are used by the scheduler and its divider.
package alt_pkg;

    localparam int DIV_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_WB,
        ST_VAR,
        ST_DONE
    } sched_state_e;

    typedef enum logic [2:0] {
        JOB_R,
        JOB_G,
        JOB_B,
        JOB_FD2,
        JOB_FD2SQ
    } job_e;

    function automatic logic [31:0] frame_pix(input int h, input int v);
        return 32'(h * v);
    endfunction

    function automatic job_e next_job(input job_e j);
        job_e n;
        case (j)
            JOB_R:   n = JOB_G;
            JOB_G:   n = JOB_B;
            JOB_B:   n = JOB_FD2;
            JOB_FD2: n = JOB_FD2SQ;
            default: n = JOB_R;
        endcase
        return n;
    endfunction

    // Ambient shifts are 8-bit; larger quotients clamp to full scale.
    function automatic logic [7:0] sat_amb(input logic [DIV_W-1:0] q);
        return (q > 64'd255) ? 8'hFF : q[7:0];
    endfunction

endpackage

// File: rtl/alt_serial_div.sv
// Restoring serial divider: 64-bit dividend by 32-bit divisor, one quotient bit per cycle.
// done is high during the cycle of the final iteration; quotient is valid from the next cycle.
module alt_serial_div
    import alt_pkg::*;
(
    input  logic             clk_pixl,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [31:0]      divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done
);

    localparam logic [6:0] LAST_ITER = 7'(DIV_W - 1);

    logic [DIV_W-1:0] quo_reg, quo_next;
    logic [31:0]      rem_reg, rem_next;
    logic [6:0]       cnt_reg, cnt_next;
    logic             run_reg, run_next;
    logic [32:0]      trial;
    logic [32:0]      diff;

    // quo_reg shifts the dividend out of its top while quotient bits enter at the bottom.
    always_comb begin
        trial    = {rem_reg, quo_reg[DIV_W-1]};
        diff     = trial - {1'b0, divisor};
        quo_next = quo_reg;
        rem_next = rem_reg;
        cnt_next = cnt_reg;
        run_next = run_reg;
        if (start) begin
            quo_next = dividend;
            rem_next = '0;
            cnt_next = '0;
            run_next = 1'b1;
        end else if (run_reg) begin
            if (trial >= {1'b0, divisor}) begin
                rem_next = diff[31:0];
                quo_next = {quo_reg[DIV_W-2:0], 1'b1};
            end else begin
                rem_next = trial[31:0];
                quo_next = {quo_reg[DIV_W-2:0], 1'b0};
            end
            cnt_next = cnt_reg + 7'd1;
            if (cnt_reg == LAST_ITER) begin
                run_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            quo_reg <= '0;
            rem_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else begin
            quo_reg <= quo_next;
            rem_reg <= rem_next;
            cnt_reg <= cnt_next;
            run_reg <= run_next;
        end
    end

    assign done     = run_reg && (cnt_reg == LAST_ITER);
    assign quotient = quo_reg;

endmodule

// File: rtl/alt_frame_sched.sv
// Raster sequencer and shared-divider statistics scheduler for the ambient-light threshold path.
// Optional ALT_SCHED_VAR_EN: adds a VAR step so covar_o = E[FD2^2] - mean^2 instead of the raw moment.
module alt_frame_sched
    import alt_pkg::*;
#(
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk_pixl,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        frame_sync_i,
    input  logic [31:0] sum_r_i,
    input  logic [31:0] sum_g_i,
    input  logic [31:0] sum_b_i,
    input  logic [63:0] sum_fd2_i,
    input  logic [63:0] sum_fd2sq_i,
    output logic [9:0]  syncX_o,
    output logic [9:0]  syncY_o,
    output logic        acc_clr_o,
    output logic        frame_end_o,
    output logic [7:0]  amb_r_o,
    output logic [7:0]  amb_g_o,
    output logic [7:0]  amb_b_o,
    output logic [31:0] mean_o,
    output logic [63:0] covar_o,
    output logic        busy_o,
    output logic        stats_valid_o,
    output logic        overrun_o
);

    localparam logic [31:0] FRAME_PIX = frame_pix(H_ACT, V_ACT);
    localparam logic [9:0]  X_LAST    = 10'(H_ACT - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_ACT - 1);

    // ---------------- raster ----------------
    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;
    logic       wrap_token;

    always_comb begin
        x_next     = x_reg;
        y_next     = y_reg;
        wrap_token = 1'b0;
        if (frame_sync_i) begin
            // A pixel accepted with the sync is itself the origin.
            x_next = (valid_i && (X_LAST != 10'd0)) ? 10'd1 : 10'd0;
            y_next = '0;
        end else if (valid_i) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                if (y_reg == Y_LAST) begin
                    y_next     = '0;
                    wrap_token = 1'b1;
                end else begin
                    y_next = y_reg + 10'd1;
                end
            end else begin
                x_next = x_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    assign syncX_o = frame_sync_i ? 10'd0 : x_reg;
    assign syncY_o = frame_sync_i ? 10'd0 : y_reg;

    // Frame-end token travels alongside the last pixel until it lands in the accumulators.
    logic [PIPE_LAT-1:0] fe_sr_reg, fe_sr_next;
    logic [PIPE_LAT:0]   fe_chain;

    assign fe_chain[0] = wrap_token;

    generate
        for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_fe_pipe
            assign fe_chain[gi+1]  = fe_sr_reg[gi];
            assign fe_sr_next[gi]  = frame_sync_i ? 1'b0 : fe_chain[gi];
        end
    endgenerate

    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            fe_sr_reg <= '0;
        end else begin
            fe_sr_reg <= fe_sr_next;
        end
    end

    assign frame_end_o = fe_chain[PIPE_LAT];
    assign acc_clr_o   = frame_end_o | frame_sync_i;

    // ---------------- scheduler FSM ----------------
    sched_state_e state_reg, state_next;
    job_e         job_reg, job_next;
    logic         div_start;
    logic         div_done;
    logic [63:0]  div_dividend;
    logic [63:0]  div_quo;

    always_comb begin
        state_next = state_reg;
        job_next   = job_reg;
        div_start  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_end_o) begin
                    state_next = ST_LOAD;
                    job_next   = JOB_R;
                end
            end
            ST_LOAD: begin
                div_start  = 1'b1;
                state_next = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                if (job_reg == JOB_FD2SQ) begin
`ifdef ALT_SCHED_VAR_EN
                    state_next = ST_VAR;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    job_next   = next_job(job_reg);
                    state_next = ST_LOAD;
                end
            end
            ST_VAR:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            job_reg   <= JOB_R;
        end else begin
            state_reg <= state_next;
            job_reg   <= job_next;
        end
    end

    // ---------------- snapshot, results ----------------
    logic [31:0] snap_r_reg, snap_g_reg, snap_b_reg;
    logic [63:0] snap_fd2_reg, snap_fd2sq_reg;
    logic [7:0]  amb_r_reg, amb_g_reg, amb_b_reg;
    logic [31:0] mean_reg;
    logic [63:0] covar_reg;
    logic        stats_valid_reg;
    logic        overrun_reg;

    // Colour sums carry two extra fraction bits into the quotient.
    always_comb begin
        div_dividend = '0;
        case (job_reg)
            JOB_R:     div_dividend = {30'd0, snap_r_reg, 2'b00};
            JOB_G:     div_dividend = {30'd0, snap_g_reg, 2'b00};
            JOB_B:     div_dividend = {30'd0, snap_b_reg, 2'b00};
            JOB_FD2:   div_dividend = snap_fd2_reg;
            JOB_FD2SQ: div_dividend = snap_fd2sq_reg;
            default:   div_dividend = '0;
        endcase
    end

    alt_serial_div u_div (
        .clk_pixl (clk_pixl),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (FRAME_PIX),
        .quotient (div_quo),
        .done     (div_done)
    );

`ifdef ALT_SCHED_VAR_EN
    logic [63:0] q_fd2sq_reg;
    logic [63:0] mean_sq;
    assign mean_sq = {32'd0, mean_reg} * {32'd0, mean_reg};
`endif

    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            snap_r_reg      <= '0;
            snap_g_reg      <= '0;
            snap_b_reg      <= '0;
            snap_fd2_reg    <= '0;
            snap_fd2sq_reg  <= '0;
            amb_r_reg       <= '0;
            amb_g_reg       <= '0;
            amb_b_reg       <= '0;
            mean_reg        <= '0;
            covar_reg       <= '0;
            stats_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
`ifdef ALT_SCHED_VAR_EN
            q_fd2sq_reg     <= '0;
`endif
        end else begin
            stats_valid_reg <= (state_reg == ST_DONE);
            // A frame end during a running sequence is dropped; that sequence finishes intact.
            if (frame_end_o) begin
                if (state_reg == ST_IDLE) begin
                    snap_r_reg     <= sum_r_i;
                    snap_g_reg     <= sum_g_i;
                    snap_b_reg     <= sum_b_i;
                    snap_fd2_reg   <= sum_fd2_i;
                    snap_fd2sq_reg <= sum_fd2sq_i;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
            if (state_reg == ST_WB) begin
                case (job_reg)
                    JOB_R:     amb_r_reg <= sat_amb(div_quo);
                    JOB_G:     amb_g_reg <= sat_amb(div_quo);
                    JOB_B:     amb_b_reg <= sat_amb(div_quo);
                    JOB_FD2:   mean_reg  <= div_quo[31:0];
`ifdef ALT_SCHED_VAR_EN
                    JOB_FD2SQ: q_fd2sq_reg <= div_quo;
`else
                    JOB_FD2SQ: covar_reg <= div_quo;
`endif
                    default: ;
                endcase
            end
`ifdef ALT_SCHED_VAR_EN
            if (state_reg == ST_VAR) begin
                covar_reg <= q_fd2sq_reg - mean_sq;
            end
`endif
        end
    end

    assign amb_r_o       = amb_r_reg;
    assign amb_g_o       = amb_g_reg;
    assign amb_b_o       = amb_b_reg;
    assign mean_o        = mean_reg;
    assign covar_o       = covar_reg;
    assign busy_o        = (state_reg != ST_IDLE);
    assign stats_valid_o = stats_valid_reg;
    assign overrun_o     = overrun_reg;

endmodule

// File: tb/tb_alt_frame_sched.sv
// Scoreboard bench for alt_frame_sched on a 4x2 raster (FRAME_PIX = 8, PIPE_LAT = 3).
// Stimulus queues expected coordinates, strobes and statistics; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_alt_frame_sched;

`ifdef ALT_SCHED_VAR_EN
    localparam int          LAT   = 333;
    localparam logic [63:0] COV_A = 64'd25;
    localparam logic [63:0] COV_B = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    localparam int          LAT   = 332;
    localparam logic [63:0] COV_A = 64'd125;
    localparam logic [63:0] COV_B = 64'd2;
`endif

    logic        clk_pixl = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        frame_sync_i;
    logic [31:0] sum_r_i, sum_g_i, sum_b_i;
    logic [63:0] sum_fd2_i, sum_fd2sq_i;
    logic [9:0]  syncX_o, syncY_o;
    logic        acc_clr_o, frame_end_o;
    logic [7:0]  amb_r_o, amb_g_o, amb_b_o;
    logic [31:0] mean_o;
    logic [63:0] covar_o;
    logic        busy_o, stats_valid_o, overrun_o;

    alt_frame_sched #(.H_ACT(4), .V_ACT(2), .PIPE_LAT(3)) dut (
        .clk_pixl      (clk_pixl),
        .reset         (reset),
        .valid_i       (valid_i),
        .frame_sync_i  (frame_sync_i),
        .sum_r_i       (sum_r_i),
        .sum_g_i       (sum_g_i),
        .sum_b_i       (sum_b_i),
        .sum_fd2_i     (sum_fd2_i),
        .sum_fd2sq_i   (sum_fd2sq_i),
        .syncX_o       (syncX_o),
        .syncY_o       (syncY_o),
        .acc_clr_o     (acc_clr_o),
        .frame_end_o   (frame_end_o),
        .amb_r_o       (amb_r_o),
        .amb_g_o       (amb_g_o),
        .amb_b_o       (amb_b_o),
        .mean_o        (mean_o),
        .covar_o       (covar_o),
        .busy_o        (busy_o),
        .stats_valid_o (stats_valid_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk_pixl = ~clk_pixl;

    int cyc = 0;
    always @(posedge clk_pixl) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
    } xy_t;

    typedef struct {
        int          cyc;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [31:0] mean;
        logic [63:0] covar;
    } stat_t;

    xy_t   coord_q[$];
    int    fe_q[$];
    int    clr_q[$];
    stat_t stats_q[$];

    int total = 0;
    int bad   = 0;

    int xs[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ys[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_pixl) begin
        xy_t   e;
        int    c;
        stat_t s;
        if (reset === 1'b1) begin
            if (valid_i) begin
                if (coord_q.size() == 0) begin
                    chk("pixel_unexpected", valid_i, 1'b0);
                end else begin
                    e = coord_q.pop_front();
                    $display("pixel cyc=%0d x=%0d y=%0d sync=%0d", cyc, syncX_o, syncY_o, frame_sync_i);
                    chk("syncX", 64'(syncX_o), 64'(e.x));
                    chk("syncY", 64'(syncY_o), 64'(e.y));
                end
            end
            if (frame_end_o) begin
                if (fe_q.size() == 0) begin
                    chk("frame_end_unexpected", frame_end_o, 1'b0);
                end else begin
                    c = fe_q.pop_front();
                    $display("frame_end cyc=%0d busy=%0d", cyc, busy_o);
                    chk("frame_end_cycle", 64'(cyc), 64'(c));
                end
            end
            if (acc_clr_o) begin
                if (clr_q.size() == 0) begin
                    chk("acc_clr_unexpected", acc_clr_o, 1'b0);
                end else begin
                    c = clr_q.pop_front();
                    chk("acc_clr_cycle", 64'(cyc), 64'(c));
                end
            end
            if (stats_valid_o) begin
                if (stats_q.size() == 0) begin
                    chk("stats_valid_unexpected", stats_valid_o, 1'b0);
                end else begin
                    s = stats_q.pop_front();
                    $display("stats cyc=%0d r=%0d g=%0d b=%0d mean=%0d covar=%0d",
                             cyc, amb_r_o, amb_g_o, amb_b_o, mean_o, covar_o);
                    chk("stats_cycle", 64'(cyc), 64'(s.cyc));
                    chk("amb_r", 64'(amb_r_o), 64'(s.r));
                    chk("amb_g", 64'(amb_g_o), 64'(s.g));
                    chk("amb_b", 64'(amb_b_o), 64'(s.b));
                    chk("mean", 64'(mean_o), 64'(s.mean));
                    chk("covar", covar_o, s.covar);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic pixel(input bit sync, input int ex, input int ey);
        xy_t e;
        e.x = ex;
        e.y = ey;
        coord_q.push_back(e);
        if (sync) clr_q.push_back(cyc);
        valid_i      = 1'b1;
        frame_sync_i = sync;
        @(posedge clk_pixl); #1;
        valid_i      = 1'b0;
        frame_sync_i = 1'b0;
    endtask

    task automatic sync_only();
        clr_q.push_back(cyc);
        frame_sync_i = 1'b1;
        @(posedge clk_pixl); #1;
        frame_sync_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_pixl); #1;
        end
    endtask

    task automatic frame8(output int fe_cyc);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                fe_cyc = cyc + 3;
                fe_q.push_back(fe_cyc);
                clr_q.push_back(fe_cyc);
            end
            pixel(1'b0, xs[i], ys[i]);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_pixl); #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((stats_q.size() != 0 || fe_q.size() != 0) && n < budget) begin
            @(posedge clk_pixl); #1;
            n++;
        end
        if (n >= budget) chk("drain_timeout_pending", 64'(stats_q.size() + fe_q.size()), 64'd0);
    endtask

    task automatic set_sums(input int r, input int g, input int b, input int fd2, input int fd2sq);
        sum_r_i     = 32'(r);
        sum_g_i     = 32'(g);
        sum_b_i     = 32'(b);
        sum_fd2_i   = 64'(fd2);
        sum_fd2sq_i = 64'(fd2sq);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int    f1, f2, f3, f4;
        stat_t s;

        reset        = 1'b0;
        valid_i      = 1'b0;
        frame_sync_i = 1'b0;
        set_sums(0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk_pixl);
        @(negedge clk_pixl);
        chk("rst_syncX", 64'(syncX_o), 64'd0);
        chk("rst_syncY", 64'(syncY_o), 64'd0);
        chk("rst_acc_clr", 64'(acc_clr_o), 64'd0);
        chk("rst_frame_end", 64'(frame_end_o), 64'd0);
        chk("rst_amb_r", 64'(amb_r_o), 64'd0);
        chk("rst_mean", 64'(mean_o), 64'd0);
        chk("rst_covar", covar_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_stats_valid", 64'(stats_valid_o), 64'd0);
        chk("rst_overrun", 64'(overrun_o), 64'd0);
        @(posedge clk_pixl); #1;
        reset = 1'b1;
        idle(3);
        @(negedge clk_pixl);
        chk("idle_syncX", 64'(syncX_o), 64'd0);
        chk("idle_syncY", 64'(syncY_o), 64'd0);
        @(posedge clk_pixl); #1;

        // Full frame, then statistics with saturation on G
        set_sums(8, 600, 20, 80, 1000);
        frame8(f1);
        s = '{f1 + LAT, 8'd4, 8'd255, 8'd10, 32'd10, COV_A};
        stats_q.push_back(s);
        wait_until(f1);
        @(negedge clk_pixl);
        chk("busy_at_frame_end", 64'(busy_o), 64'd0);
        @(posedge clk_pixl); #1;
        @(negedge clk_pixl);
        chk("busy_after_frame_end", 64'(busy_o), 64'd1);
        @(posedge clk_pixl); #1;
        drain(LAT + 20);
        @(negedge clk_pixl);
        chk("busy_after_stats", 64'(busy_o), 64'd0);
        chk("no_overrun_yet", 64'(overrun_o), 64'd0);
        @(posedge clk_pixl); #1;

        // Overrun: second frame end lands 100 cycles into the sequence
        set_sums(100, 4, 3, 17, 16);
        frame8(f2);
        s = '{f2 + LAT, 8'd50, 8'd2, 8'd1, 32'd2, COV_B};
        stats_q.push_back(s);
        wait_until(f2 + 90);
        set_sums(1000, 1000, 1000, 800, 64000);
        frame8(f3);
        drain(LAT + 20);
        wait_until(cyc + 200);
        @(negedge clk_pixl);
        chk("overrun_set", 64'(overrun_o), 64'd1);
        chk("overrun_amb_r_held", 64'(amb_r_o), 64'd50);
        chk("overrun_mean_held", 64'(mean_o), 64'd2);
        @(posedge clk_pixl); #1;

        // Reset mid-sequence
        set_sums(40, 40, 40, 40, 40);
        frame8(f4);
        wait_until(f4 + 150);
        @(negedge clk_pixl);
        chk("busy_mid_sequence", 64'(busy_o), 64'd1);
        @(posedge clk_pixl); #1;
        reset = 1'b0;
        @(negedge clk_pixl);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_amb_g", 64'(amb_g_o), 64'd0);
        chk("midrst_mean", 64'(mean_o), 64'd0);
        chk("midrst_covar", covar_o, 64'd0);
        chk("midrst_overrun", 64'(overrun_o), 64'd0);
        @(posedge clk_pixl); #1;
        @(posedge clk_pixl); #1;
        reset = 1'b1;
        wait_until(cyc + 400);
        @(negedge clk_pixl);
        chk("postrst_busy", 64'(busy_o), 64'd0);
        chk("postrst_amb_r", 64'(amb_r_o), 64'd0);
        @(posedge clk_pixl); #1;

        // Gapped pixels and frame_sync
        pixel(1'b0, 0, 0);
        idle(1);
        pixel(1'b0, 1, 0);
        idle(2);
        pixel(1'b1, 0, 0);
        idle(1);
        pixel(1'b0, 1, 0);
        pixel(1'b0, 2, 0);
        idle(1);
        sync_only();
        idle(2);
        pixel(1'b0, 0, 0);
        pixel(1'b0, 1, 0);
        idle(10);

        chk("coord_q_left", 64'(coord_q.size()), 64'd0);
        chk("fe_q_left", 64'(fe_q.size()), 64'd0);
        chk("clr_q_left", 64'(clr_q.size()), 64'd0);
        chk("stats_q_left", 64'(stats_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
